// File: rtl/gestor_carga_baterias.sv
// Dual-battery charge manager: tick-based discharge of the active battery, charging of
// the idle one(s), and automatic switch-over / exhaustion handling with registered outputs.
module gestor_carga_baterias #(
    parameter int PERIODO_TICK      = 8,
    parameter int UMBRAL_REARRANQUE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_uso,
    input  logic       cargando,
    output logic [3:0] carga_bateria1,
    output logic [3:0] carga_bateria2,
    output logic       bateria_activa,
    output logic       sin_energia,
    output logic       cambio
);

    localparam int             CW        = $clog2(PERIODO_TICK);
    localparam logic [CW-1:0]  PRESC_MAX = CW'(PERIODO_TICK - 1);
    localparam logic [3:0]     UMBRAL    = 4'(UMBRAL_REARRANQUE);

    typedef enum logic [1:0] {
        USA_B1  = 2'd0,
        USA_B2  = 2'd1,
        AGOTADO = 2'd2
    } estado_t;

    estado_t       estado, estado_sig;
    logic [CW-1:0] presc;
    logic          tick;
    logic [3:0]    c1_sig, c2_sig;
    logic          activa_sig, sin_sig, cambio_sig;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] v);
        return (v == 4'd0) ? v : v - 4'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc <= '0;
        else if (presc == PRESC_MAX)
            presc <= '0;
        else
            presc <= presc + CW'(1);
    end

    assign tick = (presc == PRESC_MAX);

    // Transitions look only at registered charge, so they land one edge after the level change.
    always_comb begin
        estado_sig = estado;
        c1_sig     = carga_bateria1;
        c2_sig     = carga_bateria2;
        case (estado)
            USA_B1: begin
                if (tick && en_uso)   c1_sig = sat_dec(carga_bateria1);
                if (tick && cargando) c2_sig = sat_inc(carga_bateria2);
                if (carga_bateria1 == 4'd0)
                    estado_sig = (carga_bateria2 != 4'd0) ? USA_B2 : AGOTADO;
            end
            USA_B2: begin
                if (tick && en_uso)   c2_sig = sat_dec(carga_bateria2);
                if (tick && cargando) c1_sig = sat_inc(carga_bateria1);
                if (carga_bateria2 == 4'd0)
                    estado_sig = (carga_bateria1 != 4'd0) ? USA_B1 : AGOTADO;
            end
            AGOTADO: begin
                if (tick && cargando) begin
                    c1_sig = sat_inc(carga_bateria1);
                    c2_sig = sat_inc(carga_bateria2);
                end
                if (carga_bateria1 >= UMBRAL)
                    estado_sig = USA_B1;
                else if (carga_bateria2 >= UMBRAL)
                    estado_sig = USA_B2;
            end
            default: estado_sig = USA_B1;
        endcase
        activa_sig = (estado_sig == USA_B2);
        sin_sig    = (estado_sig == AGOTADO);
        cambio_sig = (estado_sig != estado);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado         <= USA_B1;
            carga_bateria1 <= 4'd15;
            carga_bateria2 <= 4'd15;
            bateria_activa <= 1'b0;
            sin_energia    <= 1'b0;
            cambio         <= 1'b0;
        end else begin
            estado         <= estado_sig;
            carga_bateria1 <= c1_sig;
            carga_bateria2 <= c2_sig;
            bateria_activa <= activa_sig;
            sin_energia    <= sin_sig;
            cambio         <= cambio_sig;
        end
    end

endmodule

// File: tb/tb_gestor_carga_baterias.sv
// Directed bench for gestor_carga_baterias with PERIODO_TICK=4, UMBRAL_REARRANQUE=4.
module tb_gestor_carga_baterias;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en_uso = 1'b0;
    logic       cargando = 1'b0;
    logic [3:0] carga_bateria1, carga_bateria2;
    logic       bateria_activa, sin_energia, cambio;

    int n_chk = 0;
    int n_ok  = 0;

    gestor_carga_baterias #(.PERIODO_TICK(4), .UMBRAL_REARRANQUE(4)) dut (
        .clk(clk), .rst_n(rst_n), .en_uso(en_uso), .cargando(cargando),
        .carga_bateria1(carga_bateria1), .carga_bateria2(carga_bateria2),
        .bateria_activa(bateria_activa), .sin_energia(sin_energia), .cambio(cambio)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic u, input logic c);
        en_uso   = u;
        cargando = c;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (carga_bateria1 !== 4'd15) $display("FAIL reset_c1: got %0d want 15", carga_bateria1); else n_ok++;
        n_chk++; if (carga_bateria2 !== 4'd15) $display("FAIL reset_c2: got %0d want 15", carga_bateria2); else n_ok++;
        n_chk++; if (bateria_activa !== 1'b0) $display("FAIL reset_activa: got %b want 0", bateria_activa); else n_ok++;
        n_chk++; if (sin_energia !== 1'b0) $display("FAIL reset_sin: got %b want 0", sin_energia); else n_ok++;
        n_chk++; if (cambio !== 1'b0) $display("FAIL reset_cambio: got %b want 0", cambio); else n_ok++;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_descarga();
        do_reset();
        set_in(1'b1, 1'b0);
        step(59);
        n_chk++; if (carga_bateria1 !== 4'd1) $display("FAIL desc_c1_14ticks: got %0d want 1", carga_bateria1); else n_ok++;
        step(1);
        n_chk++; if (carga_bateria1 !== 4'd0) $display("FAIL desc_c1_15ticks: got %0d want 0", carga_bateria1); else n_ok++;
        n_chk++; if (bateria_activa !== 1'b0) $display("FAIL desc_activa_pre: got %b want 0", bateria_activa); else n_ok++;
        step(1);
        n_chk++; if (bateria_activa !== 1'b1) $display("FAIL desc_activa_b2: got %b want 1", bateria_activa); else n_ok++;
        n_chk++; if (cambio !== 1'b1) $display("FAIL desc_cambio_b2: got %b want 1", cambio); else n_ok++;
        n_chk++; if (carga_bateria2 !== 4'd15) $display("FAIL desc_c2_full: got %0d want 15", carga_bateria2); else n_ok++;
        n_chk++; if (sin_energia !== 1'b0) $display("FAIL desc_sin_b2: got %b want 0", sin_energia); else n_ok++;
        step(1);
        n_chk++; if (cambio !== 1'b0) $display("FAIL desc_cambio_pulse: got %b want 0", cambio); else n_ok++;
        // battery 2 ticks land on edges 64..120 after release
        step(58);
        n_chk++; if (carga_bateria2 !== 4'd0) $display("FAIL desc_c2_empty: got %0d want 0", carga_bateria2); else n_ok++;
        n_chk++; if (sin_energia !== 1'b0) $display("FAIL desc_sin_pre: got %b want 0", sin_energia); else n_ok++;
        step(1);
        n_chk++; if (sin_energia !== 1'b1) $display("FAIL agot_sin: got %b want 1", sin_energia); else n_ok++;
        n_chk++; if (bateria_activa !== 1'b0) $display("FAIL agot_activa: got %b want 0", bateria_activa); else n_ok++;
        n_chk++; if (cambio !== 1'b1) $display("FAIL agot_cambio: got %b want 1", cambio); else n_ok++;
        step(8);
        n_chk++; if (carga_bateria1 !== 4'd0) $display("FAIL agot_c1_hold: got %0d want 0", carga_bateria1); else n_ok++;
        n_chk++; if (carga_bateria2 !== 4'd0) $display("FAIL agot_c2_hold: got %0d want 0", carga_bateria2); else n_ok++;
        n_chk++; if (sin_energia !== 1'b1) $display("FAIL agot_sin_hold: got %b want 1", sin_energia); else n_ok++;
        n_chk++; if (cambio !== 1'b0) $display("FAIL agot_cambio_hold: got %b want 0", cambio); else n_ok++;
    endtask

    task automatic test_recarga();
        set_in(1'b0, 1'b1);
        step(15);
        n_chk++; if (carga_bateria1 !== 4'd4) $display("FAIL rec_c1: got %0d want 4", carga_bateria1); else n_ok++;
        n_chk++; if (carga_bateria2 !== 4'd4) $display("FAIL rec_c2: got %0d want 4", carga_bateria2); else n_ok++;
        n_chk++; if (sin_energia !== 1'b1) $display("FAIL rec_sin_pre: got %b want 1", sin_energia); else n_ok++;
        step(1);
        n_chk++; if (sin_energia !== 1'b0) $display("FAIL rec_sin: got %b want 0", sin_energia); else n_ok++;
        n_chk++; if (bateria_activa !== 1'b0) $display("FAIL rec_activa: got %b want 0", bateria_activa); else n_ok++;
        n_chk++; if (cambio !== 1'b1) $display("FAIL rec_cambio: got %b want 1", cambio); else n_ok++;
        step(1);
        n_chk++; if (cambio !== 1'b0) $display("FAIL rec_cambio_pulse: got %b want 0", cambio); else n_ok++;
    endtask

    task automatic test_uso_y_carga();
        set_in(1'b0, 1'b0);
        step(2);
        set_in(1'b1, 1'b1);
        step(16);
        n_chk++; if (carga_bateria1 !== 4'd0 || carga_bateria2 !== 4'd8) $display("FAIL uc_swap_levels: got %0d/%0d want 0/8", carga_bateria1, carga_bateria2); else n_ok++;
        step(1);
        n_chk++; if (bateria_activa !== 1'b1 || cambio !== 1'b1) $display("FAIL uc_to_b2: got activa=%b cambio=%b want 1/1", bateria_activa, cambio); else n_ok++;
        set_in(1'b0, 1'b0);
        step(3);
        set_in(1'b0, 1'b1);
        step(40);
        set_in(1'b1, 1'b0);
        step(32);
        n_chk++; if (carga_bateria1 !== 4'd10 || carga_bateria2 !== 4'd0) $display("FAIL uc_b2_drain: got %0d/%0d want 10/0", carga_bateria1, carga_bateria2); else n_ok++;
        step(1);
        n_chk++; if (bateria_activa !== 1'b0 || cambio !== 1'b1) $display("FAIL uc_to_b1: got activa=%b cambio=%b want 0/1", bateria_activa, cambio); else n_ok++;
        set_in(1'b0, 1'b0);
        step(3);
        set_in(1'b0, 1'b1);
        step(20);
        n_chk++; if (carga_bateria1 !== 4'd10 || carga_bateria2 !== 4'd5) $display("FAIL uc_setup: got %0d/%0d want 10/5", carga_bateria1, carga_bateria2); else n_ok++;
        set_in(1'b1, 1'b1);
        step(12);
        n_chk++; if (carga_bateria1 !== 4'd7 || carga_bateria2 !== 4'd8) $display("FAIL uc_both: got %0d/%0d want 7/8", carga_bateria1, carga_bateria2); else n_ok++;
        n_chk++; if (bateria_activa !== 1'b0 || cambio !== 1'b0 || sin_energia !== 1'b0) $display("FAIL uc_state: got activa=%b cambio=%b sin=%b want 0/0/0", bateria_activa, cambio, sin_energia); else n_ok++;
        step(3);
        n_chk++; if (carga_bateria1 !== 4'd7 || carga_bateria2 !== 4'd8) $display("FAIL uc_no_tick: got %0d/%0d want 7/8", carga_bateria1, carga_bateria2); else n_ok++;
    endtask

    task automatic test_saturacion();
        set_in(1'b0, 1'b0);
        step(1);
        set_in(1'b0, 1'b1);
        step(40);
        n_chk++; if (carga_bateria2 !== 4'd15) $display("FAIL sat_c2_top: got %0d want 15", carga_bateria2); else n_ok++;
        n_chk++; if (carga_bateria1 !== 4'd7) $display("FAIL sat_c1_keep: got %0d want 7", carga_bateria1); else n_ok++;
        set_in(1'b1, 1'b0);
        step(28);
        n_chk++; if (carga_bateria1 !== 4'd0 || carga_bateria2 !== 4'd15) $display("FAIL sat_c1_floor: got %0d/%0d want 0/15", carga_bateria1, carga_bateria2); else n_ok++;
        step(1);
        n_chk++; if (bateria_activa !== 1'b1 || cambio !== 1'b1) $display("FAIL sat_to_b2: got activa=%b cambio=%b want 1/1", bateria_activa, cambio); else n_ok++;
    endtask

    task automatic test_reset_medio();
        set_in(1'b0, 1'b0);
        step(3);
        set_in(1'b1, 1'b1);
        step(12);
        set_in(1'b1, 1'b0);
        step(24);
        n_chk++; if (carga_bateria1 !== 4'd3 || carga_bateria2 !== 4'd6 || bateria_activa !== 1'b1) $display("FAIL rm_setup: got %0d/%0d activa=%b want 3/6/1", carga_bateria1, carga_bateria2, bateria_activa); else n_ok++;
        set_in(1'b0, 1'b0);
        step(2);
        rst_n = 1'b0;
        #1;
        n_chk++; if (carga_bateria1 !== 4'd15 || carga_bateria2 !== 4'd15) $display("FAIL rm_levels: got %0d/%0d want 15/15", carga_bateria1, carga_bateria2); else n_ok++;
        n_chk++; if (bateria_activa !== 1'b0 || cambio !== 1'b0 || sin_energia !== 1'b0) $display("FAIL rm_flags: got activa=%b cambio=%b sin=%b want 0/0/0", bateria_activa, cambio, sin_energia); else n_ok++;
        step(1);
        rst_n = 1'b1;
        set_in(1'b1, 1'b0);
        step(3);
        n_chk++; if (carga_bateria1 !== 4'd15) $display("FAIL rm_no_early_tick: got %0d want 15", carga_bateria1); else n_ok++;
        step(1);
        n_chk++; if (carga_bateria1 !== 4'd14) $display("FAIL rm_first_tick: got %0d want 14", carga_bateria1); else n_ok++;
        n_chk++; if (bateria_activa !== 1'b0) $display("FAIL rm_activa: got %b want 0", bateria_activa); else n_ok++;
    endtask

    initial begin
        test_reset();
        test_descarga();
        test_recarga();
        test_uso_y_carga();
        test_saturacion();
        test_reset_medio();
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
